// File: rtl/alu_seq_if.sv
// Request/response bundle between the register-file side and alu_seq.
// The master drives operation requests and the slave returns results with flags.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             E;
  logic             start;
  logic [3:0]       Mode;
  logic [WIDTH-1:0] Operand1;
  logic [WIDTH-1:0] Operand2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Out;
  logic [WIDTH-1:0] Out_hi;
  logic [3:0]       CFlags;
  logic             Flags;

  modport master (
    output E, start, Mode, Operand1, Operand2,
    input  busy, done, Out, Out_hi, CFlags, Flags
  );

  modport slave (
    input  E, start, Mode, Operand1, Operand2,
    output busy, done, Out, Out_hi, CFlags, Flags
  );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with a start/busy/done handshake.
// Logic and add/sub ops finish in one cycle; MUL (shift-add) and DIV (restoring) iterate WIDTH cycles.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic      clk,
  input logic      rst_n,
  alu_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_NOT,
    OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_CMP, OP_INC, OP_DEC, OP_RSVD
  } op_t;

  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic [WIDTH-1:0] part_hi;
  logic [WIDTH-1:0] part_lo;
  logic [WIDTH-1:0] operand;
  logic             busy_q;
  logic             done_q;
  logic             flags_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_hi_q;
  logic [3:0]       cflags_q;

  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH:0]   wide;
  logic             c_f;
  logic             v_f;
  logic             err_f;
  logic             iterate;

  assign op      = op_t'(bus.Mode);
  assign a       = bus.Operand1;
  assign b       = bus.Operand2;
  assign iterate = (op == OP_MUL || op == OP_DIV) && (b != '0);

  // MUL/DIV only reach this path with a zero Operand2.
  always_comb begin
    res    = '0;
    res_hi = '0;
    wide   = '0;
    c_f    = 1'b0;
    v_f    = 1'b0;
    err_f  = 1'b0;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b};
        res  = wide[MSB:0];
        c_f  = wide[WIDTH];
        v_f  = (a[MSB] == b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        wide = {1'b0, a} - {1'b0, b};
        res  = wide[MSB:0];
        c_f  = wide[WIDTH];
        v_f  = (a[MSB] != b[MSB]) && (res[MSB] != a[MSB]);
      end
      OP_MUL: res = '0;
      OP_DIV: begin
        res    = '1;
        res_hi = a;
        err_f  = 1'b1;
      end
      OP_AND: res = a & b;
      OP_OR:  res = a | b;
      OP_XOR: res = a ^ b;
      OP_NOT: res = ~a;
      OP_SHL: begin
        res = {a[MSB-1:0], 1'b0};
        c_f = a[MSB];
      end
      OP_SHR: begin
        res = {1'b0, a[MSB:1]};
        c_f = a[0];
      end
      OP_ROL: begin
        res = {a[MSB-1:0], a[MSB]};
        c_f = a[MSB];
      end
      OP_ROR: begin
        res = {a[0], a[MSB:1]};
        c_f = a[0];
      end
      OP_INC: begin
        wide = {1'b0, a} + (WIDTH+1)'(1);
        res  = wide[MSB:0];
        c_f  = wide[WIDTH];
        v_f  = !a[MSB] && res[MSB];
      end
      OP_DEC: begin
        wide = {1'b0, a} - (WIDTH+1)'(1);
        res  = wide[MSB:0];
        c_f  = wide[WIDTH];
        v_f  = a[MSB] && !res[MSB];
      end
      default: err_f = 1'b1;
    endcase
  end

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic             rem_ge;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic             mul_c;

  // One iteration step: part_hi holds the partial product / remainder, part_lo the multiplier / quotient.
  always_comb begin
    mul_sum  = {1'b0, part_hi} + (part_lo[0] ? {1'b0, operand} : '0);
    rem_sh   = {part_hi, part_lo[MSB]};
    rem_diff = rem_sh - {1'b0, operand};
    rem_ge   = rem_sh >= {1'b0, operand};
    if (is_div) begin
      hi_n = rem_ge ? rem_diff[MSB:0] : rem_sh[MSB:0];
      lo_n = {part_lo[MSB-1:0], rem_ge};
    end else begin
      hi_n = mul_sum[WIDTH:1];
      lo_n = {mul_sum[0], part_lo[MSB:1]};
    end
    mul_c = !is_div && (hi_n != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      is_div   <= 1'b0;
      part_hi  <= '0;
      part_lo  <= '0;
      operand  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      flags_q  <= 1'b0;
      out_q    <= '0;
      out_hi_q <= '0;
      cflags_q <= '0;
    end else if (bus.E) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (iterate) begin
              state   <= EXEC;
              cnt     <= CNT_W'(WIDTH);
              is_div  <= (op == OP_DIV);
              part_hi <= '0;
              part_lo <= a;
              operand <= b;
            end else begin
              state    <= DONE;
              done_q   <= 1'b1;
              flags_q  <= err_f;
              cflags_q <= {c_f, res == '0, res[MSB], v_f};
              if (op != OP_CMP) begin
                out_q    <= res;
                out_hi_q <= res_hi;
              end
            end
          end
        end
        EXEC: begin
          part_hi <= hi_n;
          part_lo <= lo_n;
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state    <= DONE;
            done_q   <= 1'b1;
            flags_q  <= 1'b0;
            out_q    <= lo_n;
            out_hi_q <= hi_n;
            cflags_q <= {mul_c, lo_n == '0, lo_n[MSB], mul_c};
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.Out    = out_q;
  assign bus.Out_hi = out_hi_q;
  assign bus.CFlags = cflags_q;
  assign bus.Flags  = flags_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboarded random test of alu_seq (WIDTH=8) against an arithmetic reference model,
// plus directed 16-bit multiply latency checks on a second instance.
`timescale 1ns/1ps
module tb_alu_seq;
  localparam int W   = 8;
  localparam int W16 = 16;

  logic clk = 1'b0;
  logic rst_n;

  alu_seq_if #(.WIDTH(W))   bus ();
  alu_seq_if #(.WIDTH(W16)) bus16 ();

  alu_seq #(.WIDTH(W))   dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  alu_seq #(.WIDTH(W16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] out;
    logic [63:0] hi;
    logic [3:0]  cflags;
    logic        flags;
    int          lat;
    int          start_cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] last_out = '0;
  logic [63:0] last_hi = '0;
  logic        mon_prev_done = 1'b0;
  exp_t        mon_e;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic longint sgn(input logic [63:0] x);
    return x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
  endfunction

  // Expected result from plain integer arithmetic; tracks the last Out/Out_hi for CMP.
  function automatic exp_t refModel(input int mode, input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    logic [63:0] m = (64'd1 << W) - 1;
    logic [63:0] p;
    logic [63:0] fv;
    logic        c = 1'b0;
    logic        v = 1'b0;
    longint      smin = -(longint'(1) << (W - 1));
    longint      smax = (longint'(1) << (W - 1)) - 1;
    longint      s;
    e.hi    = '0;
    e.flags = 1'b0;
    e.lat   = 1;
    e.name  = $sformatf("mode%0d(%0h,%0h)", mode, a, b);
    case (mode)
      0: begin
        p = a + b; e.out = p & m; c = p > m;
        s = sgn(a) + sgn(b); v = (s < smin) || (s > smax);
      end
      1, 12: begin
        e.out = (a - b) & m; c = a < b;
        s = sgn(a) - sgn(b); v = (s < smin) || (s > smax);
      end
      2: begin
        p = a * b; e.out = p & m; e.hi = p >> W; c = e.hi != 0; v = c;
        if (b != 0) e.lat = W + 1;
      end
      3: begin
        if (b == 0) begin
          e.out = m; e.hi = a; e.flags = 1'b1;
        end else begin
          e.out = a / b; e.hi = a % b; e.lat = W + 1;
        end
      end
      4:  e.out = a & b;
      5:  e.out = a | b;
      6:  e.out = a ^ b;
      7:  e.out = ~a & m;
      8:  begin e.out = (a << 1) & m; c = a[W-1]; end
      9:  begin e.out = a >> 1; c = a[0]; end
      10: begin e.out = ((a << 1) | (a >> (W - 1))) & m; c = a[W-1]; end
      11: begin e.out = (a >> 1) | ((a & 1) << (W - 1)); c = a[0]; end
      13: begin p = a + 1; e.out = p & m; c = p > m; s = sgn(a) + 1; v = s > smax; end
      14: begin e.out = (a + m) & m; c = a == 0; s = sgn(a) - 1; v = s < smin; end
      default: begin e.out = '0; e.flags = 1'b1; end
    endcase
    fv = e.out;
    if (mode == 12) begin
      e.out = last_out;
      e.hi  = last_hi;
    end
    e.cflags = {c, fv == 0, fv[W-1], v};
    last_out = e.out;
    last_hi  = e.hi;
    return e;
  endfunction

  task automatic issueOp(input int mode, input logic [W-1:0] a, input logic [W-1:0] b, input int stalls);
    exp_t e;
    @(negedge clk);
    e = refModel(mode, 64'(a), 64'(b));
    e.start_cyc = cyc;
    if (e.lat > 1) e.lat += stalls;
    sb.push_back(e);
    bus.start    = 1'b1;
    bus.Mode     = 4'(mode);
    bus.Operand1 = a;
    bus.Operand2 = b;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.Mode     = 4'($urandom);
    bus.Operand1 = W'($urandom);
    bus.Operand2 = W'($urandom);
  endtask

  task automatic waitIdle();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL timeout: %0d responses outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Long ops get E dropped for 'stalls' cycles and a stray start pulse while busy.
  task automatic applyStimulus(input int mode, input logic [W-1:0] a, input logic [W-1:0] b, input int stalls);
    issueOp(mode, a, b, stalls);
    if ((mode == 2 || mode == 3) && b != 0) begin
      repeat (3) @(negedge clk);
      bus.E = 1'b0;
      repeat (stalls) @(negedge clk);
      bus.E        = 1'b1;
      bus.start    = 1'b1;
      bus.Mode     = 4'($urandom);
      bus.Operand1 = W'($urandom);
      bus.Operand2 = W'($urandom);
      @(negedge clk);
      bus.start = 1'b0;
    end
    waitIdle();
  endtask

  task automatic run16(input int stalls, output int lat);
    lat = -1;
    @(negedge clk);
    bus16.start    = 1'b1;
    bus16.Mode     = 4'd2;
    bus16.Operand1 = 16'hFFFF;
    bus16.Operand2 = 16'hFFFF;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      bus16.start = 1'b0;
      if (bus16.done === 1'b1) begin
        lat = k;
        break;
      end
      bus16.E = (k >= 3 && k < 3 + stalls) ? 1'b0 : 1'b1;
    end
    bus16.E = 1'b1;
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.done === 1'b1 && !mon_prev_done) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL spurious done: got done=1, expected no pending op");
        end else begin
          mon_e = sb.pop_front();
          checkOutput({mon_e.name, " Out"},     64'(bus.Out),    mon_e.out);
          checkOutput({mon_e.name, " Out_hi"},  64'(bus.Out_hi), mon_e.hi);
          checkOutput({mon_e.name, " CFlags"},  64'(bus.CFlags), 64'(mon_e.cflags));
          checkOutput({mon_e.name, " Flags"},   64'(bus.Flags),  64'(mon_e.flags));
          checkOutput({mon_e.name, " latency"}, 64'(cyc - mon_e.start_cyc), 64'(mon_e.lat));
          checkOutput({mon_e.name, " busy"},    64'(bus.busy),   64'd1);
        end
      end
      mon_prev_done = bus.done;
    end
  end

  initial begin : watchdog
    #1ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    int lat16;
    bus.E = 1'b1;   bus.start = 1'b0;   bus.Mode = '0;   bus.Operand1 = '0;   bus.Operand2 = '0;
    bus16.E = 1'b1; bus16.start = 1'b0; bus16.Mode = '0; bus16.Operand1 = '0; bus16.Operand2 = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset busy",   64'(bus.busy),   64'd0);
    checkOutput("reset done",   64'(bus.done),   64'd0);
    checkOutput("reset Out",    64'(bus.Out),    64'd0);
    checkOutput("reset Out_hi", 64'(bus.Out_hi), 64'd0);
    checkOutput("reset CFlags", 64'(bus.CFlags), 64'd0);
    checkOutput("reset Flags",  64'(bus.Flags),  64'd0);
    rst_n = 1'b1;

    applyStimulus(0,  8'd12,  8'd5, 0);
    applyStimulus(1,  8'd5,   8'd12, 0);
    applyStimulus(2,  8'd200, 8'd3, 0);
    applyStimulus(3,  8'd100, 8'd7, 0);
    applyStimulus(3,  8'd37,  8'd0, 0);
    applyStimulus(10, 8'h81,  8'h00, 0);
    applyStimulus(12, 8'd9,   8'd9, 0);
    applyStimulus(15, 8'h5A,  8'hA5, 0);
    applyStimulus(2,  8'hFF,  8'hFF, 3);
    applyStimulus(2,  8'd0,   8'd77, 1);
    applyStimulus(2,  8'd13,  8'd0, 0);
    applyStimulus(13, 8'h7F,  8'h00, 0);
    applyStimulus(14, 8'h80,  8'h00, 0);
    applyStimulus(14, 8'h00,  8'h00, 0);

    for (int i = 0; i < 60; i++) begin
      int          mode;
      logic [W-1:0] a;
      logic [W-1:0] b;
      mode = int'($urandom_range(0, 15));
      a    = W'($urandom);
      b    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      applyStimulus(mode, a, b, int'($urandom_range(0, 3)));
    end

    // Hold done across disabled cycles.
    issueOp(6, 8'h3C, 8'h0F, 0);
    bus.E = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("E low holds done", 64'(bus.done), 64'd1);
    end
    bus.E = 1'b1;
    @(negedge clk);
    checkOutput("done drops after E returns", 64'(bus.done), 64'd0);
    waitIdle();

    // Asynchronous reset in the middle of a multiply.
    applyStimulus(0, 8'd3, 8'd4, 0);
    @(negedge clk);
    bus.start = 1'b1; bus.Mode = 4'd2; bus.Operand1 = 8'd200; bus.Operand2 = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midop reset busy",   64'(bus.busy),   64'd0);
    checkOutput("midop reset done",   64'(bus.done),   64'd0);
    checkOutput("midop reset Out",    64'(bus.Out),    64'd0);
    checkOutput("midop reset CFlags", 64'(bus.CFlags), 64'd0);
    last_out = '0;
    last_hi  = '0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'd1, 8'd1, 0);
    repeat (12) @(negedge clk);
    checkOutput("no done after aborted MUL", 64'(bus.done), 64'd0);

    run16(0, lat16);
    checkOutput("w16 MUL latency",  64'(lat16),         64'd17);
    checkOutput("w16 MUL Out",      64'(bus16.Out),     64'h0001);
    checkOutput("w16 MUL Out_hi",   64'(bus16.Out_hi),  64'hFFFE);
    checkOutput("w16 MUL CFlags",   64'(bus16.CFlags),  64'b1001);
    run16(3, lat16);
    checkOutput("w16 MUL stalled latency", 64'(lat16),     64'd20);
    checkOutput("w16 MUL stalled Out_hi",  64'(bus16.Out_hi), 64'hFFFE);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
